fft_sequencer: RTL
==================

FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter FFT_N, default 1024, meaning transform length (power of two, 8..4096); L = log2(FFT_N) derived.
REQ-002 SHALL have parameter STAGE_LAT, default 2, meaning register latency per butterfly stage.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  input sample present this cycle; frame first sample coincides with in_sof.
REQ-006 in_sof  in  1  first sample of an input frame.
REQ-007 en  out  1  enable to every stage delay line.
REQ-008 pad_zero  out  1  forces pipeline input sample to zero.
REQ-009 stage_ctrl  out  L  bit s = ctrl for stage s (s=0 first).
REQ-010 stage_addr  out  L*L  slice [s*L +: L] = twiddle address of stage s, bits above L-1-s zero.
REQ-011 out_valid, out_sof, out_eof  out  1 each  output sample qualifiers.
REQ-012 out_idx  out  L  frequency index of current output sample.
REQ-013 err  out  1  one-cycle pulse on frame abort; busy  out  1  state != IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN, FLUSH; global counter g (L bits, wraps at FFT_N).
REQ-015 IDLE: g=0, en=0, pad_zero=1; in_valid&in_sof -> RUN, g increments that cycle.
REQ-016 RUN: en=1, g increments every cycle; pad_zero=0 while in_valid, else 1.
REQ-017 RUN, g wraps to 0 with in_valid&in_sof -> stay RUN (back-to-back frames, no gap cycle).
REQ-018 RUN, g wraps to 0 without in_valid&in_sof -> FLUSH.
REQ-019 RUN, in_valid low at g != 0 -> frame aborted: err pulse, pad_zero=1 for remainder of frame, frame marked bad; in_sof at g != 0 ignored and also aborts.
REQ-020 FLUSH: en=1, pad_zero=1, g runs; in_valid&in_sof at g==0 -> RUN; after LAT cycles with no accepted frame -> IDLE.
REQ-021 Stage s counter c_s = (g - OFF_s) mod FFT_N, OFF_s = s*STAGE_LAT + FFT_N - FFT_N/2^s.
REQ-022 stage_ctrl[s] = bit (L-1-s) of c_s; stage_addr slice s = low (L-1-s) bits of c_s; both registered, one cycle after g.
REQ-023 Output latency LAT = FFT_N - 1 + L*STAGE_LAT cycles from input sample to its output sample.
REQ-024 Frame tracking: FIFO of one status bit per frame (good/bad), depth ceil(LAT/FFT_N)+1; pushed at input frame start, popped at output frame end.
REQ-025 out_valid=1 only for samples of good frames; out_sof at output index 0, out_eof at FFT_N-1, both gated by out_valid.
REQ-026 FIFO full at push SHALL not occur by construction; assertion required.

Reset
REQ-027 rst SHALL force IDLE, g=0, FIFO empty, en=0, pad_zero=1, stage_ctrl=0, stage_addr=0, out_valid/out_sof/out_eof/err=0, out_idx=0, busy=0.
REQ-028 rst mid-frame SHALL discard all in-flight frames; no out_valid until a new frame completes LAT.

Configuration
REQ-029 FFT_SEQ_BITREV_EN defined: out_idx = bit-reverse of output sample counter (natural-order frequency index).
REQ-030 FFT_SEQ_BITREV_EN undefined: out_idx = raw output sample counter (arrival order); all else identical.

Structure
REQ-031 Shared package fft_pkg: sequencer state enum, LAT/OFF_s computation functions, bit-reverse function.
REQ-032 Sub-module fft_frame_fifo (status-bit FIFO, parameter depth) SHALL be separate.

Verification
REQ-033 FFT_N=16, STAGE_LAT=2: one frame of 16 valid samples -> out_valid 16 cycles starting LAT=23 cycles after first in_valid, out_sof/out_eof on first/last.
REQ-034 Three back-to-back frames -> en never drops, out_valid continuous 48 cycles, FLUSH then IDLE after last.
REQ-035 in_valid low at g=5 -> err pulse one cycle, pad_zero high to g=15, that frame produces no out_valid; next frame normal.
REQ-036 rst asserted at g=9 of second frame -> all outputs zero same cycle, no outputs until a fresh frame.
REQ-037 Check stage_ctrl[0] toggles every 8 cycles, stage_ctrl[3] every cycle, offset per REQ-021 for FFT_N=16.
REQ-038 With FFT_SEQ_BITREV_EN, out_idx sequence 0,8,4,12,...; without, 0,1,2,...,15.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT sequencer: state encoding, latency and
// per-stage counter offsets, and a bit-reverse for output indexing.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_t;

  localparam int MAX_L = 12;

  function automatic int calc_lat(input int n, input int sl);
    return n - 1 + $clog2(n) * sl;
  endfunction

  function automatic int calc_off(input int s, input int n, input int sl);
    return s * sl + n - (n >> s);
  endfunction

  // Reverse the low l bits of x: full-width reverse, then drop the unused top.
  function automatic logic [MAX_L-1:0] bitrev(input logic [MAX_L-1:0] x, input int l);
    logic [MAX_L-1:0] r;
    for (int i = 0; i < MAX_L; i++) r[i] = x[MAX_L-1-i];
    return r >> (MAX_L - l);
  endfunction

endpackage

// File: rtl/fft_frame_fifo.sv
// One status bit per in-flight frame slot (1 = good frame). The newest entry
// can be cleared in place when its frame aborts after it was pushed.
module fft_frame_fifo #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic din,
  input  logic pop,
  input  logic mark_bad,
  output logic dout,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr, last_ptr;
  logic [CW-1:0]    cnt;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | pop);
  assign last_ptr = (wr_ptr == '0) ? AW'(DEPTH - 1) : wr_ptr - 1'b1;
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (mark_bad && !empty) mem[last_ptr] <= 1'b0;
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for a pipelined radix-2 FFT: drives stage enables, per-stage
// ctrl/twiddle addresses and output qualifiers. FFT_SEQ_BITREV_EN selects natural-order out_idx.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter  int FFT_N     = 1024,
  parameter  int STAGE_LAT = 2,
  localparam int L         = $clog2(FFT_N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_sof,
  output logic           en,
  output logic           pad_zero,
  output logic [L-1:0]   stage_ctrl,
  output logic [L*L-1:0] stage_addr,
  output logic           out_valid,
  output logic           out_sof,
  output logic           out_eof,
  output logic [L-1:0]   out_idx,
  output logic           err,
  output logic           busy
);

  localparam int LAT   = calc_lat(FFT_N, STAGE_LAT);
  localparam int DEPTH = (LAT + FFT_N - 1) / FFT_N + 1;
  localparam int LW    = $clog2(LAT + 1);

  seq_state_t     state, state_n;
  logic [L-1:0]   g, o;
  logic [LW-1:0]  fcnt, lead;
  logic           out_on, bad_cur;
  logic           start, wrap, abort, push, pop, clr, head, fifo_empty;
  logic [L-1:0]   ctrl_d;
  logic [L*L-1:0] addr_d;

  assign start = in_valid & in_sof;
  assign wrap  = (g == '0);
  assign busy  = (state != IDLE);
  assign abort = (state == RUN) & ~wrap & (~in_valid | in_sof) & ~bad_cur;
  assign err   = abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (wrap && !start) state_n = FLUSH;
      FLUSH:   if (wrap && start) state_n = RUN;
               else if (fcnt == LW'(LAT - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The accepting cycle in IDLE/FLUSH already carries sample 0 into the pipe.
  always_comb begin
    en       = 1'b0;
    pad_zero = 1'b1;
    case (state)
      IDLE:    begin en = start; pad_zero = ~start; end
      RUN:     begin en = 1'b1;  pad_zero = wrap ? ~start : (~in_valid | in_sof | bad_cur); end
      FLUSH:   begin en = 1'b1;  pad_zero = ~(wrap & start); end
      default: begin en = 1'b0;  pad_zero = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g       <= '0;
      fcnt    <= '0;
      bad_cur <= 1'b0;
      lead    <= '0;
      out_on  <= 1'b0;
      o       <= '0;
    end else begin
      g       <= (state_n == IDLE) ? '0 : g + 1'b1;
      fcnt    <= (state_n != FLUSH) ? '0 : (state == FLUSH) ? fcnt + 1'b1 : LW'(1);
      if (push && start) bad_cur <= 1'b0;
      else if (abort)    bad_cur <= 1'b1;
      // Output slots line up LAT cycles after the first accepted sample of a busy period.
      if (state_n == IDLE) begin
        lead   <= '0;
        out_on <= 1'b0;
        o      <= '0;
      end else begin
        if (!out_on) lead <= lead + 1'b1;
        if (!out_on && lead == LW'(LAT - 1)) out_on <= 1'b1;
        if (out_on) o <= o + 1'b1;
      end
    end
  end

  // Every slot boundary pushes a status; empty slots count as bad frames.
  assign push = wrap & (busy | start);
  assign pop  = out_on & (o == '1);
  assign clr  = (state_n == IDLE);

  fft_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .din      (start),
    .pop      (pop),
    .mark_bad (abort),
    .dout     (head),
    .empty    (fifo_empty)
  );

  assign out_valid = out_on & ~fifo_empty & head;
  assign out_sof   = out_valid & (o == '0);
  assign out_eof   = out_valid & (o == '1);

`ifdef FFT_SEQ_BITREV_EN
  assign out_idx = L'(bitrev(MAX_L'(o), L));
`else
  assign out_idx = o;
`endif

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam logic [L-1:0] OFF  = L'(calc_off(s, FFT_N, STAGE_LAT) % FFT_N);
    localparam logic [L-1:0] MASK = L'((1 << (L - 1 - s)) - 1);
    logic [L-1:0] c;
    assign c                 = g - OFF;
    assign ctrl_d[s]         = c[L-1-s];
    assign addr_d[s*L +: L]  = c & MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_ctrl <= '0;
      stage_addr <= '0;
    end else begin
      stage_ctrl <= ctrl_d;
      stage_addr <= addr_d;
    end
  end

endmodule
